// File: rtl/axil_write_master.sv
`default_nettype none
// ============================================================================
// axil_write_master: FIFO-buffers dealigner beats and issues one AXI4-Lite
// write per beat to consecutive word addresses. Option: AXIL_SKIP_ZERO_STRB_EN
// Revision: 1.0
// ============================================================================
module axil_write_master #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] start_addr,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic [3:0]  in_strb,
    input  logic        in_last,
    output logic        busy,
    output logic        done,
    output logic        resp_err,
    output logic        overflow,
    output logic [31:0] m_awaddr,
    output logic [2:0]  m_awprot,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic [1:0]  m_bresp,
    input  logic        m_bvalid,
    output logic        m_bready
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT      = 2'd1,
        ADDR_DATA = 2'd2,
        RESP      = 2'd3
    } state_t;

    state_t      state;
    logic [36:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [31:0] addr;
    logic        last_seen;
    logic        beat_last;

    logic        empty;
    logic        full;
    logic        start_ok;
    logic        pop;
    logic        push;
    logic        drop;
    logic [36:0] head;
    logic        skip_beat;
    logic        aw_fire;
    logic        w_fire;
    logic        aw_ok;
    logic        w_ok;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign start_ok = start && (state != ADDR_DATA) && (state != RESP);
    assign pop      = (state == WAIT) && !empty && !start_ok;
    // A full FIFO still accepts a beat when the head leaves on the same edge.
    assign push     = in_valid && busy && (!full || pop) && !start_ok;
    assign drop     = in_valid && busy && full && !pop && !start_ok;
    assign head     = fifo_mem[rd_ptr[AW-1:0]];

`ifdef AXIL_SKIP_ZERO_STRB_EN
    assign skip_beat = (head[4:1] == 4'b0000);
`else
    assign skip_beat = 1'b0;
`endif

    assign aw_fire  = m_awvalid && m_awready;
    assign w_fire   = m_wvalid && m_wready;
    assign aw_ok    = !m_awvalid || m_awready;
    assign w_ok     = !m_wvalid || m_wready;

    assign m_awaddr = addr;
    assign m_awprot = 3'b000;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= {in_data, in_strb, in_last};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            addr      <= 32'd0;
            last_seen <= 1'b0;
            beat_last <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            resp_err  <= 1'b0;
            overflow  <= 1'b0;
            m_awvalid <= 1'b0;
            m_wvalid  <= 1'b0;
            m_wdata   <= 32'd0;
            m_wstrb   <= 4'd0;
            m_bready  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
            if (drop) begin
                overflow <= 1'b1;
                // A dropped final beat must still let the transfer terminate.
                if (in_last) last_seen <= 1'b1;
            end

            if (start_ok) begin
                addr      <= start_addr & 32'hFFFF_FFFC;
                rd_ptr    <= wr_ptr;
                resp_err  <= 1'b0;
                overflow  <= 1'b0;
                last_seen <= 1'b0;
                busy      <= 1'b1;
                state     <= WAIT;
            end else begin
                case (state)
                    IDLE: ;
                    WAIT: begin
                        if (!empty) begin
                            m_wdata   <= head[36:5];
                            m_wstrb   <= head[4:1];
                            beat_last <= head[0];
                            if (skip_beat) begin
                                if (head[0]) begin
                                    done  <= 1'b1;
                                    busy  <= 1'b0;
                                    state <= IDLE;
                                end else begin
                                    addr <= addr + 32'd4;
                                end
                            end else begin
                                m_awvalid <= 1'b1;
                                m_wvalid  <= 1'b1;
                                state     <= ADDR_DATA;
                            end
                        end else if (last_seen) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                    ADDR_DATA: begin
                        if (aw_fire) m_awvalid <= 1'b0;
                        if (w_fire)  m_wvalid  <= 1'b0;
                        if (aw_ok && w_ok) begin
                            m_bready <= 1'b1;
                            state    <= RESP;
                        end
                    end
                    RESP: begin
                        if (m_bvalid && m_bready) begin
                            m_bready <= 1'b0;
                            if (m_bresp != 2'b00) resp_err <= 1'b1;
                            if (beat_last) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                addr  <= addr + 32'd4;
                                state <= WAIT;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_axil_write_master.sv
`default_nettype none
// ============================================================================
// tb_axil_write_master: directed stimulus against a transaction-level model.
// Revision: 1.0
// ============================================================================
module tb_axil_write_master;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] start_addr = 32'd0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'd0;
    logic [3:0]  in_strb = 4'd0;
    logic        in_last = 1'b0;
    logic        busy, done, resp_err, overflow;
    logic [31:0] m_awaddr;
    logic [2:0]  m_awprot;
    logic        m_awvalid;
    logic        m_awready = 1'b1;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready = 1'b1;
    logic [1:0]  m_bresp;
    logic        m_bvalid = 1'b1;
    logic        m_bready;

    always #5 clk = ~clk;

    axil_write_master #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .in_valid(in_valid), .in_data(in_data), .in_strb(in_strb), .in_last(in_last),
        .busy(busy), .done(done), .resp_err(resp_err), .overflow(overflow),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  s;
        logic        l;
    } beat_t;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Slave answers with SLVERR on the second response of a transfer when err_mode is set.
    bit err_mode = 1'b0;
    int bcnt = 0;
    always_comb m_bresp = (err_mode && bcnt == 1) ? 2'b10 : 2'b00;

    // Model state: queue of buffered beats plus the one write in flight.
    beat_t       mdl_q[$];
    beat_t       mdl_cur = '0;
    bit          mdl_armed = 0, mdl_infl = 0, mdl_aw = 0, mdl_w = 0, mdl_b = 0;
    bit          mdl_done = 0, mdl_err = 0, mdl_ovf = 0, mdl_last_seen = 0;
    logic [31:0] mdl_addr = 32'd0;

    logic [31:0] aw_log[$];
    logic [35:0] w_log[$];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : model
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mdl_q.delete();
                mdl_cur = '0;
                {mdl_armed, mdl_infl, mdl_aw, mdl_w, mdl_b} = '0;
                {mdl_done, mdl_err, mdl_ovf, mdl_last_seen} = '0;
                mdl_addr = 32'd0;
                bcnt <= 0;
            end else begin
                bit    armed0, pop, full, skip;
                beat_t h;
                mdl_done = 0;
                armed0 = mdl_armed;
                if (start && !mdl_infl) begin
                    mdl_q.delete();
                    mdl_addr = {start_addr[31:2], 2'b00};
                    mdl_err = 0;
                    mdl_ovf = 0;
                    mdl_last_seen = 0;
                    mdl_armed = 1;
                    bcnt <= 0;
                end else begin
                    pop  = armed0 && !mdl_infl && mdl_q.size() > 0;
                    full = (mdl_q.size() == DEPTH);
                    if (armed0 && !mdl_infl && mdl_q.size() == 0 && mdl_last_seen) begin
                        mdl_done = 1;
                        mdl_armed = 0;
                    end
                    if (mdl_infl) begin
                        if (mdl_b) begin
                            if (m_bvalid) begin
                                mdl_b = 0;
                                mdl_infl = 0;
                                bcnt <= bcnt + 1;
                                if (m_bresp != 2'b00) mdl_err = 1;
                                if (mdl_cur.l) begin
                                    mdl_done = 1;
                                    mdl_armed = 0;
                                end else begin
                                    mdl_addr = mdl_addr + 32'd4;
                                end
                            end
                        end else begin
                            if (mdl_aw && m_awready) mdl_aw = 0;
                            if (mdl_w && m_wready) mdl_w = 0;
                            if (!mdl_aw && !mdl_w) mdl_b = 1;
                        end
                    end
                    if (pop) begin
                        h = mdl_q.pop_front();
                        mdl_cur = h;
`ifdef AXIL_SKIP_ZERO_STRB_EN
                        skip = (h.s == 4'b0000);
`else
                        skip = 0;
`endif
                        if (skip) begin
                            if (h.l) begin
                                mdl_done = 1;
                                mdl_armed = 0;
                            end else begin
                                mdl_addr = mdl_addr + 32'd4;
                            end
                        end else begin
                            mdl_infl = 1;
                            mdl_aw = 1;
                            mdl_w = 1;
                        end
                    end
                    if (in_valid && armed0) begin
                        if (!full || pop) begin
                            mdl_q.push_back('{d: in_data, s: in_strb, l: in_last});
                        end else begin
                            mdl_ovf = 1;
                            if (in_last) mdl_last_seen = 1;
                        end
                    end
                end
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk1("awvalid", m_awvalid, mdl_aw);
                chk1("wvalid", m_wvalid, mdl_w);
                chk1("bready", m_bready, mdl_b);
                chk1("busy", busy, mdl_armed);
                chk1("done", done, mdl_done);
                chk1("resp_err", resp_err, mdl_err);
                chk1("overflow", overflow, mdl_ovf);
                chk32("awprot", {29'd0, m_awprot}, 32'd0);
                if (mdl_aw) chk32("awaddr", m_awaddr, mdl_addr);
                if (mdl_w) begin
                    chk32("wdata", m_wdata, mdl_cur.d);
                    chk32("wstrb", {28'd0, m_wstrb}, {28'd0, mdl_cur.s});
                end
                if (m_awvalid && m_awready) aw_log.push_back(m_awaddr);
                if (m_wvalid && m_wready) w_log.push_back({m_wdata, m_wstrb});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] a);
        aw_log.delete();
        w_log.delete();
        start = 1'b1;
        start_addr = a;
        tick();
        start = 1'b0;
    endtask

    task automatic push(input logic [31:0] d, input logic [3:0] s, input logic l);
        in_valid = 1'b1;
        in_data = d;
        in_strb = s;
        in_last = l;
        tick();
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk1(name, seen, 1'b1);
        tick();
    endtask

    initial begin : stim
        tick();
        tick();
        rst = 1'b0;
        chk_en = 1'b1;
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_awvalid", m_awvalid, 1'b0);
        chk32("reset_awaddr", m_awaddr, 32'd0);

        // Beat while idle is ignored.
        push(32'hDEAD_BEEF, 4'hF, 1'b1);
        repeat (3) tick();
        chk1("idle_ignore", m_awvalid, 1'b0);

        // Three beats, always-ready slave, unaligned start.
        do_start(32'h0000_1003);
        push(32'h1111_1111, 4'hF, 1'b0);
        push(32'h2222_2222, 4'h3, 1'b0);
        push(32'h3333_3333, 4'h8, 1'b1);
        wait_done(60, "t1_done");
        chk1("t1_busy_after", busy, 1'b0);
        chk32("t1_aw0", aw_log[0], 32'h0000_1000);
        chk32("t1_aw1", aw_log[1], 32'h0000_1004);
        chk32("t1_aw2", aw_log[2], 32'h0000_1008);
        chk32("t1_strb1", {28'd0, w_log[1][3:0]}, 32'h3);
        chk32("t1_strb2", {28'd0, w_log[2][3:0]}, 32'h8);

        // W channel stalled; AW accepted at once.
        m_wready = 1'b0;
        do_start(32'h0000_2000);
        push(32'hA5A5_0001, 4'hF, 1'b1);
        repeat (5) tick();
        chk1("t2_aw_dropped", m_awvalid, 1'b0);
        chk1("t2_w_held", m_wvalid, 1'b1);
        chk32("t2_wdata", m_wdata, 32'hA5A5_0001);
        chk1("t2_no_resp", m_bready, 1'b0);
        m_wready = 1'b1;
        wait_done(30, "t2_done");

        // AW stalled while ten beats arrive back to back.
        m_awready = 1'b0;
        do_start(32'h0000_3000);
        for (int i = 0; i < 10; i++) push(32'hC000_0000 + i, 4'hF, i == 9);
        repeat (10) tick();
        chk1("t3_overflow", overflow, 1'b1);
        m_awready = 1'b1;
        wait_done(200, "t3_done");
        chk32("t3_aw_count", aw_log.size(), 32'd9);
        chk32("t3_aw_last", aw_log[8], 32'h0000_3020);
        chk32("t3_w_last", w_log[8][35:4], 32'hC000_0008);
        chk1("t3_overflow_sticky", overflow, 1'b1);

        // SLVERR on the middle beat.
        err_mode = 1'b1;
        do_start(32'h0000_4000);
        push(32'h0000_0041, 4'hF, 1'b0);
        push(32'h0000_0042, 4'hF, 1'b0);
        push(32'h0000_0043, 4'hF, 1'b1);
        wait_done(60, "t4_done");
        err_mode = 1'b0;
        chk1("t4_resp_err", resp_err, 1'b1);
        chk32("t4_aw2", aw_log[2], 32'h0000_4008);

        // Address wrap at the top of memory.
        do_start(32'hFFFF_FFFC);
        chk1("t5_err_cleared", resp_err, 1'b0);
        push(32'h0000_0051, 4'hF, 1'b0);
        push(32'h0000_0052, 4'hF, 1'b1);
        wait_done(40, "t5_done");
        chk32("t5_aw0", aw_log[0], 32'hFFFF_FFFC);
        chk32("t5_aw1", aw_log[1], 32'h0000_0000);

        // Zero-strobe middle beat.
        do_start(32'h0000_0000);
        push(32'h0000_0061, 4'hF, 1'b0);
        push(32'h0000_0062, 4'h0, 1'b0);
        push(32'h0000_0063, 4'hF, 1'b1);
        wait_done(60, "t6_done");
`ifdef AXIL_SKIP_ZERO_STRB_EN
        chk32("t6_aw_count", aw_log.size(), 32'd2);
        chk32("t6_aw0", aw_log[0], 32'h0000_0000);
        chk32("t6_aw1", aw_log[1], 32'h0000_0008);
`else
        chk32("t6_aw_count", aw_log.size(), 32'd3);
        chk32("t6_aw1", aw_log[1], 32'h0000_0004);
        chk32("t6_strb_null", {28'd0, w_log[1][3:0]}, 32'h0);
`endif

        // Reset in the middle of an address phase.
        m_awready = 1'b0;
        do_start(32'h0000_5000);
        push(32'h0000_0071, 4'hF, 1'b1);
        tick();
        chk1("t7_awvalid_up", m_awvalid, 1'b1);
        rst = 1'b1;
        #1;
        chk1("t7_rst_awvalid", m_awvalid, 1'b0);
        chk1("t7_rst_wvalid", m_wvalid, 1'b0);
        chk1("t7_rst_bready", m_bready, 1'b0);
        chk1("t7_rst_busy", busy, 1'b0);
        tick();
        rst = 1'b0;
        m_awready = 1'b1;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
